fetch_ifid_stage: RTL and testbench
===================================

// Module: fetch_ifid_stage
// PURPOSE
//  Fetch stage plus IF/ID pipeline register for the 16-bit pipelined core. Owns the PC and issues
//  requests to a multi-cycle instruction memory. Consumes the load-to-use stall from the hazard
//  detector and the branch/jump redirect from execute. Presents one instruction per cycle to decode.
//  A 1-entry hold buffer absorbs a fetch response that returns while decode is stalled.
// PARAMETERS
//  RESET_PC   16'h0000  PC value loaded on reset
//  NOP_INSTR  16'h0800  encoding driven on instr_id when invalid (NOP, opcode 00001)
// PORTS
//  clk             in   1   clock, all state updates on rising edge
//  rst_n           in   1   asynchronous, active-low reset
//  imem_req        out  1   read request, valid for one cycle per request
//  imem_addr       out  16  request address (= pc)
//  imem_rdata      in   16  instruction data, valid when imem_done=1
//  imem_done       in   1   response for the single outstanding request (same cycle as req on hit)
//  load_use_stall  in   1   hold IF/ID contents (from load-to-use detector)
//  redirect        in   1   flush and restart fetch at redirect_pc
//  redirect_pc     in   16  target PC, word aligned
//  instr_id        out  16  instruction in IF/ID
//  pc_plus2_id     out  16  address of instr_id + 2
//  valid_id        out  1   instr_id is a real instruction (0 = bubble)
//  halted          out  1   HALT has been delivered to decode; fetch stopped
// BEHAVIOUR
//  Reset (async): pc=RESET_PC, state=REQ, hold_valid=0, instr_id=NOP_INSTR, pc_plus2_id=0,
//   valid_id=0, halted=0. imem_req=1 in the first cycle after rst_n rises.
//  FSM states: REQ, WAIT, DROP, HALT. At most one request is outstanding.
//   REQ: imem_req = ~hold_valid. Issued and done -> response accepted, stay REQ.
//        Issued and not done -> WAIT.
//   WAIT: imem_req=0. On done -> response accepted, go REQ.
//   DROP: imem_req=0. On done -> discard data, go REQ. pc already holds redirect target.
//   HALT: imem_req=0 permanently. Only redirect or reset leaves.
//  Accepting a response: pc <= pc+2 (mod 2^16, wraps FFFE->0000).
//   If the accepted opcode [15:11]==5'b00000 (HALT) -> next state HALT.
//  IF/ID update, priority high to low, evaluated every cycle:
//   1 redirect: valid_id<=0, instr_id<=NOP_INSTR, hold_valid<=0, pc<=redirect_pc.
//     If a request is outstanding (WAIT, or REQ issued without done) -> DROP, else -> REQ.
//     A same-cycle response is discarded. Redirect in HALT clears halted.
//   2 load_use_stall: IF/ID holds. An accepted response goes to the hold buffer (hold_valid<=1).
//   3 hold_valid: IF/ID <= hold buffer, valid_id<=1, hold_valid<=0.
//   4 response accepted: IF/ID <= {imem_rdata, pc+2}, valid_id<=1.
//   5 otherwise: instr_id<=NOP_INSTR, valid_id<=0 (pc_plus2_id holds).
//  No request is issued while hold_valid=1, so the hold buffer never overflows.
//  halted<=1 on the edge where the HALT instruction is written into IF/ID, and stays set.
//  redirect and load_use_stall together: redirect wins, so the stalled wrong-path instruction is flushed.
//  rst_n asserted mid-request: the response is lost. Memory is also reset by the same rst_n.
// TESTING
//  1 Reset, then 1-cycle-hit memory at 0x0000..0x0006: instr_id follows one per cycle,
//    pc_plus2_id = 2,4,6,8, valid_id=1 from cycle 2.
//  2 Memory latency 3 cycles: imem_req pulses every 4 cycles.
//    valid_id=1 for 1 cycle in 4, NOP_INSTR otherwise.
//  3 load_use_stall held 2 cycles while a response returns: IF/ID unchanged, hold_valid=1,
//    no new imem_req. Stall drops -> buffered instr in ID next cycle, then request resumes.
//  4 redirect to 0x0040 while in WAIT: the pending response is dropped (never reaches ID).
//    The next request has imem_addr=0x0040. instr_id=NOP_INSTR for the flush cycle.
//  5 Fetch 16'h0000 (HALT): halted=1 the cycle it enters ID, no further imem_req.
//    A later redirect to 0x0010 clears halted and resumes fetch.
//  6 redirect_pc=0xFFFE with hits: fetch 0xFFFE then 0x0000 (pc wrap), pc_plus2_id=0x0000 then 0x0002.

Source files
------------

// File: rtl/fetch_ifid_stage_if.sv
// -----------------------------------------------------------------------------
// fetch_ifid_stage_if
//   Request/response bus between the fetch stage and the instruction memory.
//   At most one request is outstanding. A hit may complete in the same cycle
//   the request is raised.
//   req    fetch -> imem  read request, one cycle per request
//   addr   fetch -> imem  request address (current pc)
//   rdata  imem -> fetch  instruction word, valid when done=1
//   done   imem -> fetch  response for the outstanding request
// -----------------------------------------------------------------------------
interface fetch_ifid_stage_if;
    logic        req;
    logic [15:0] addr;
    logic [15:0] rdata;
    logic        done;

    modport master (output req, output addr, input rdata, input done);
    modport slave  (input req, input addr, output rdata, output done);
endinterface

// File: rtl/fetch_ifid_stage.sv
// -----------------------------------------------------------------------------
// fetch_ifid_stage
//   Fetch stage and IF/ID pipeline register of the 16-bit core. Owns the pc,
//   talks to a multi-cycle instruction memory, honours the load-to-use stall
//   and the execute-stage redirect, and presents one instruction per cycle to
//   decode. A one-entry hold buffer catches a response that lands while decode
//   is stalled; no new request is issued while it is occupied.
// Ports
//   clk, rst_n      clock / asynchronous active-low reset
//   imem            instruction memory bus (master side)
//   load_use_stall  hold IF/ID contents
//   redirect        flush and restart fetch at redirect_pc
//   redirect_pc     word-aligned restart address
//   instr_id        instruction in IF/ID (NOP_INSTR when invalid)
//   pc_plus2_id     address of instr_id + 2
//   valid_id        instr_id is a real instruction
//   halted          HALT has reached decode; fetch stopped
// -----------------------------------------------------------------------------
module fetch_ifid_stage #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = 16'h0800
) (
    input  logic                       clk,
    input  logic                       rst_n,
    fetch_ifid_stage_if.master         imem,
    input  logic                       load_use_stall,
    input  logic                       redirect,
    input  logic [15:0]                redirect_pc,
    output logic [15:0]                instr_id,
    output logic [15:0]                pc_plus2_id,
    output logic                       valid_id,
    output logic                       halted
);

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP, S_HALT} state_t;

    state_t      state, state_nxt;
    logic [15:0] pc;
    logic [15:0] pc_inc;
    logic        hold_valid;
    logic [15:0] hold_instr;
    logic [15:0] hold_pc2;

    logic        issued;
    logic        resp_live;
    logic        accept;
    logic        accept_halt;
    logic        busy_after;
    logic        from_hold;
    logic        from_resp;

    assign pc_inc      = pc + 16'd2;
    assign issued      = (state == S_REQ) && !hold_valid;
    // A done in DROP belongs to a flushed request and is never a live response.
    assign resp_live   = imem.done && (issued || state == S_WAIT);
    assign accept      = resp_live && !redirect;
    assign accept_halt = accept && (imem.rdata[15:11] == 5'b00000);
    // A request is still in flight after this cycle only if nothing came back now;
    // a redirect coinciding with the response therefore restarts directly in REQ.
    assign busy_after  = (issued || state == S_WAIT || state == S_DROP) && !imem.done;

    assign from_hold   = !redirect && !load_use_stall && hold_valid;
    assign from_resp   = !redirect && !load_use_stall && !hold_valid && accept;

    // ---- FSM: state register ------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_REQ;
        else        state <= state_nxt;
    end

    // ---- FSM: next state ----------------------------------------------------
    always_comb begin
        state_nxt = state;
        if (redirect) begin
            state_nxt = busy_after ? S_DROP : S_REQ;
        end else begin
            case (state)
                S_REQ: begin
                    if (issued) begin
                        if (!imem.done)       state_nxt = S_WAIT;
                        else if (accept_halt) state_nxt = S_HALT;
                    end
                end
                S_WAIT: begin
                    if (imem.done) state_nxt = accept_halt ? S_HALT : S_REQ;
                end
                S_DROP: begin
                    if (imem.done) state_nxt = S_REQ;
                end
                default: state_nxt = S_HALT;
            endcase
        end
    end

    // ---- FSM: outputs -------------------------------------------------------
    always_comb begin
        imem.req  = issued;
        imem.addr = pc;
    end

    // ---- pc, hold buffer, IF/ID ---------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            hold_valid  <= 1'b0;
            hold_instr  <= NOP_INSTR;
            hold_pc2    <= 16'h0000;
            instr_id    <= NOP_INSTR;
            pc_plus2_id <= 16'h0000;
            valid_id    <= 1'b0;
            halted      <= 1'b0;
        end else begin
            if (redirect)    pc <= redirect_pc;
            else if (accept) pc <= pc_inc;

            if (redirect) begin
                valid_id   <= 1'b0;
                instr_id   <= NOP_INSTR;
                hold_valid <= 1'b0;
                halted     <= 1'b0;
            end else if (load_use_stall) begin
                if (accept) begin
                    hold_valid <= 1'b1;
                    hold_instr <= imem.rdata;
                    hold_pc2   <= pc_inc;
                end
            end else if (hold_valid) begin
                instr_id    <= hold_instr;
                pc_plus2_id <= hold_pc2;
                valid_id    <= 1'b1;
                hold_valid  <= 1'b0;
            end else if (accept) begin
                instr_id    <= imem.rdata;
                pc_plus2_id <= pc_inc;
                valid_id    <= 1'b1;
            end else begin
                instr_id <= NOP_INSTR;
                valid_id <= 1'b0;
            end

            // halted rises on the edge the HALT word lands in IF/ID.
            if ((from_hold && hold_instr[15:11] == 5'b00000) || (from_resp && accept_halt))
                halted <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fetch_ifid_stage.sv
module tb_fetch_ifid_stage;
    localparam logic [15:0] NOP = 16'h0800;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load_use_stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic [15:0] instr_id;
    logic [15:0] pc_plus2_id;
    logic        valid_id;
    logic        halted;

    fetch_ifid_stage_if mif();

    fetch_ifid_stage #(.RESET_PC(16'h0000), .NOP_INSTR(NOP)) dut (
        .clk(clk), .rst_n(rst_n), .imem(mif),
        .load_use_stall(load_use_stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .instr_id(instr_id), .pc_plus2_id(pc_plus2_id), .valid_id(valid_id), .halted(halted)
    );

    always #5 clk = ~clk;

    // Memory image indexed by word address.
    logic [15:0] mem [0:32767];

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: memory transaction tracker plus program-order streams.
    int          lat_mode;      // <0: random latency 0..3, else fixed
    bit          pending;
    int          cnt;
    logic [15:0] paddr;
    bit          stale;         // outstanding response belongs to a flushed path
    logic [15:0] exp_fetch_pc;  // next address memory should be asked for
    bit          fetch_stopped; // HALT word accepted, no more requests expected
    logic [15:0] exp_id_pc;     // address of next instruction decode should see
    bit          exp_halted;
    int          deliveries;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        pending = 0; cnt = 0; stale = 0; paddr = '0;
        exp_fetch_pc = 16'h0000; fetch_stopped = 0;
        exp_id_pc = 16'h0000; exp_halted = 0;
    endtask

    // One clock cycle: respond as memory, drive inputs, check the result of the edge.
    task automatic tick(input bit st, input bit rd, input logic [15:0] rpc);
        logic [15:0] s_instr, s_pc2, rdat, w;
        logic        s_vld;
        bit          done, acc;
        int          l;
        s_instr = instr_id; s_pc2 = pc_plus2_id; s_vld = valid_id;
        done = 0; acc = 0; rdat = '0;
        if (mif.req === 1'b1) begin
            check("req_allowed", {31'd0, !pending && !fetch_stopped}, 32'd1);
            check("req_addr", {16'd0, mif.addr}, {16'd0, exp_fetch_pc});
        end
        if (pending) begin
            cnt--;
            if (cnt == 0) begin
                done = 1; pending = 0;
                rdat = mem[paddr[15:1]];
                acc  = !stale && !rd;
            end else if (rd) begin
                stale = 1;
            end
        end else if (mif.req === 1'b1) begin
            l = (lat_mode < 0) ? int'($urandom_range(0, 3)) : lat_mode;
            if (l == 0) begin
                done = 1;
                rdat = mem[mif.addr[15:1]];
                acc  = !rd;
            end else begin
                pending = 1; cnt = l; paddr = mif.addr; stale = rd;
            end
        end
        if (acc) begin
            exp_fetch_pc = exp_fetch_pc + 16'd2;
            if (rdat[15:11] == 5'b00000) fetch_stopped = 1;
        end
        if (rd) begin
            exp_fetch_pc = rpc; fetch_stopped = 0;
        end
        mif.done       = done;
        mif.rdata      = done ? rdat : 16'($urandom);
        load_use_stall = st;
        redirect       = rd;
        redirect_pc    = rpc;
        @(posedge clk); #1;
        if (rd) begin
            check("flush_valid", {31'd0, valid_id}, 32'd0);
            check("flush_instr", {16'd0, instr_id}, {16'd0, NOP});
            exp_id_pc = rpc; exp_halted = 0;
        end else if (st) begin
            check("stall_instr", {16'd0, instr_id}, {16'd0, s_instr});
            check("stall_pc2", {16'd0, pc_plus2_id}, {16'd0, s_pc2});
            check("stall_valid", {31'd0, valid_id}, {31'd0, s_vld});
        end else if (valid_id === 1'b1) begin
            w = mem[exp_id_pc[15:1]];
            check("id_after_halt", 32'd1, {31'd0, !exp_halted});
            check("id_instr", {16'd0, instr_id}, {16'd0, w});
            check("id_pc2", {16'd0, pc_plus2_id}, {16'd0, exp_id_pc + 16'd2});
            if (w[15:11] == 5'b00000) exp_halted = 1;
            exp_id_pc = exp_id_pc + 16'd2;
            deliveries++;
        end else begin
            check("bubble_instr", {16'd0, instr_id}, {16'd0, NOP});
        end
        check("halted", {31'd0, halted}, {31'd0, exp_halted});
    endtask

    task automatic fill_mem(input int halt_odds);
        logic [15:0] v;
        for (int i = 0; i < 32768; i++) begin
            v = 16'($urandom);
            if (halt_odds > 0 && $urandom_range(0, halt_odds) == 0) v[15:11] = 5'b00000;
            else if (v[15:11] == 5'b00000) v[11] = 1'b1;
            mem[i] = v;
        end
    endtask

    initial begin
        rst_n = 1'b0; load_use_stall = 0; redirect = 0; redirect_pc = '0;
        mif.done = 0; mif.rdata = '0;
        lat_mode = 0; deliveries = 0;
        fill_mem(0);
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_instr", {16'd0, instr_id}, {16'd0, NOP});
        check("rst_valid", {31'd0, valid_id}, 32'd0);
        check("rst_pc2", {16'd0, pc_plus2_id}, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        rst_n = 1'b1;
        #1;
        check("rst_req", {31'd0, mif.req}, 32'd1);
        check("rst_addr", {16'd0, mif.addr}, 32'd0);

        // 1: single-cycle hits stream 0x0000..0x0006
        for (int i = 0; i < 4; i++) begin
            tick(0, 0, '0);
            check("t1_valid", {31'd0, valid_id}, 32'd1);
            check("t1_pc2", {16'd0, pc_plus2_id}, 32'(2 * (i + 1)));
        end

        // 2: latency 3 -> one request and one valid every 4 cycles
        lat_mode = 3;
        for (int i = 0; i < 12; i++) begin
            check("t2_req", {31'd0, mif.req}, {31'd0, (i % 4) == 0});
            tick(0, 0, '0);
            check("t2_valid", {31'd0, valid_id}, {31'd0, (i % 4) == 3});
        end

        // 3: stall for 2 cycles while the response lands
        lat_mode = 1;
        check("t3_req0", {31'd0, mif.req}, 32'd1);
        tick(0, 0, '0);
        tick(1, 0, '0);
        check("t3_req_held1", {31'd0, mif.req}, 32'd0);
        tick(1, 0, '0);
        check("t3_req_held2", {31'd0, mif.req}, 32'd0);
        tick(0, 0, '0);
        check("t3_buf_valid", {31'd0, valid_id}, 32'd1);
        check("t3_req_resume", {31'd0, mif.req}, 32'd1);

        // 4: redirect to 0x0040 while waiting; pending response dropped
        mem[16'h0040 >> 1] = 16'h5A5A;
        mem[16'h0042 >> 1] = 16'h0000;
        lat_mode = 3;
        tick(0, 0, '0);
        tick(0, 1, 16'h0040);
        tick(0, 0, '0);
        check("t4_no_req", {31'd0, mif.req}, 32'd0);
        tick(0, 0, '0);
        check("t4_req", {31'd0, mif.req}, 32'd1);
        check("t4_addr", {16'd0, mif.addr}, 32'h0040);

        // 5: HALT at 0x0042, then redirect to 0x0010
        lat_mode = 0;
        tick(0, 0, '0);
        check("t5_addr_halt", {16'd0, mif.addr}, 32'h0042);
        tick(0, 0, '0);
        check("t5_halted", {31'd0, halted}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            check("t5_no_req", {31'd0, mif.req}, 32'd0);
            tick(0, 0, '0);
        end
        tick(0, 1, 16'h0010);
        check("t5_unhalt", {31'd0, halted}, 32'd0);
        check("t5_resume_addr", {16'd0, mif.addr}, 32'h0010);

        // 6: pc wraps from 0xFFFE to 0x0000
        tick(0, 1, 16'hFFFE);
        check("t6_addr", {16'd0, mif.addr}, 32'hFFFE);
        tick(0, 0, '0);
        check("t6_pc2_a", {16'd0, pc_plus2_id}, 32'h0000);
        check("t6_addr_wrap", {16'd0, mif.addr}, 32'h0000);
        tick(0, 0, '0);
        check("t6_pc2_b", {16'd0, pc_plus2_id}, 32'h0002);

        // Random traffic: latency, stalls, redirects, occasional HALT words
        fill_mem(40);
        lat_mode = -1;
        deliveries = 0;
        tick(0, 1, 16'($urandom) & 16'hFFFE);
        for (int i = 0; i < 3000; i++) begin
            tick($urandom_range(0, 3) == 0, $urandom_range(0, 14) == 0,
                 16'($urandom) & 16'hFFFE);
        end
        check("progress", {31'd0, deliveries > 300}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
